// File: rtl/res_halfword_serializer.sv
// res_halfword_serializer: buffers tagged 32-bit results and emits them as two 16-bit beats, upper half first.
// Words tagged sel==7 are dropped and counted instead of buffered.
module res_halfword_serializer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_res,
  input  logic [2:0]       in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_last,
  output logic [2:0]       out_sel,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, HI, LO} state_t;
  state_t          state_q, state_d;
  logic [34:0]     mem_q [DEPTH];
  logic [AW:0]     wr_q, wr_d, rd_q, rd_d, used;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic            full, empty, accept, push, pop;
  logic [34:0]     head;
  // pointers carry one extra wrap bit so full and empty are distinguishable
  assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty  = wr_q == rd_q;
  assign used   = wr_q - rd_q;
  assign in_ready = !full;
  assign accept = in_valid && in_ready;
  assign push   = accept && in_sel != 3'd7;
  assign pop    = state_q == LO && out_ready;
  assign head   = mem_q[rd_q[AW-1:0]];
  assign wr_d   = wr_q + {{AW{1'b0}}, push};
  assign rd_d   = rd_q + {{AW{1'b0}}, pop};
  assign drop_d = drop_q + {{(CNT_W-1){1'b0}}, accept && in_sel == 3'd7 && !(&drop_q)};
  assign drop_cnt = drop_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      drop_q  <= drop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {in_sel, in_res};
  end
  // a push in the LO handshake cycle keeps the stream going even if the pop empties the FIFO
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (!empty || push) ? HI : IDLE;
      HI:      state_d = out_ready ? LO : HI;
      LO:      state_d = !out_ready ? LO : (used > (AW+1)'(1) || push) ? HI : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    out_valid = state_q != IDLE;
    out_last  = state_q == LO;
    out_sel   = out_valid ? head[34:32] : 3'd0;
    out_data  = state_q == HI ? head[31:16] : state_q == LO ? head[15:0] : 16'h0;
  end
endmodule

// File: tb/tb_res_halfword_serializer.sv
// tb_res_halfword_serializer: directed scenarios plus random traffic checked every cycle against a queue-based model.
module tb_res_halfword_serializer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_res = 0;
  logic [2:0]  in_sel = 0;
  logic        in_ready, out_valid, out_last;
  logic [15:0] out_data;
  logic [2:0]  out_sel;
  logic [CNT_W-1:0] drop_cnt;
  int n_cmp = 0, n_err = 0;

  res_halfword_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_res(in_res), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_sel(out_sel), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: list of buffered {sel,res} words plus whether the head's upper beat has been taken
  logic [34:0] q[$];
  bit lo = 0;
  int dc = 0;
  always @(negedge clk) begin
    logic [34:0] h;
    bit acc, adv;
    if (!rst_n) begin q.delete(); lo = 0; dc = 0; end
    chk("m_in_ready", in_ready, q.size() < DEPTH);
    chk("m_out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      h = q[0];
      chk("m_out_data", out_data, lo ? h[15:0] : h[31:16]);
      chk("m_out_last", out_last, lo);
      chk("m_out_sel", out_sel, h[34:32]);
    end else chk("m_idle_sel", out_sel, 0);
    chk("m_drop_cnt", drop_cnt, dc);
    if (rst_n) begin
      acc = in_valid && q.size() < DEPTH;
      adv = q.size() != 0 && out_ready;
      if (adv && lo) begin void'(q.pop_front()); lo = 0; end
      else if (adv) lo = 1;
      if (acc && in_sel == 3'd7) dc = dc < (1 << CNT_W) - 1 ? dc + 1 : dc;
      else if (acc) q.push_back({in_sel, in_res});
    end
  end

  task automatic step(input logic v, input logic [31:0] r, input logic [2:0] s, input logic rdy);
    @(posedge clk); #1;
    in_valid = v; in_res = r; in_sel = s; out_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    int beats;
    bit took;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    @(posedge clk); #1 rst_n = 1;

    // single word
    step(1, 32'hDEAD_BEEF, 0, 1);
    chk("sw_pre_valid", out_valid, 0);
    step(0, 0, 0, 1);
    chk("sw_hi_data", out_data, 16'hDEAD);
    chk("sw_hi_last", out_last, 0);
    chk("sw_hi_sel", out_sel, 0);
    step(0, 0, 0, 1);
    chk("sw_lo_data", out_data, 16'hBEEF);
    chk("sw_lo_last", out_last, 1);
    step(0, 0, 0, 1);
    chk("sw_idle", out_valid, 0);

    // fill and backpressure
    for (int k = 1; k <= 4; k++) begin
      step(1, {16'hA000 + 16'(k), 16'hB000 + 16'(k)}, 3'(k), 0);
      chk("fill_ready", in_ready, 1);
    end
    step(1, 32'hA005_B005, 5, 0);
    chk("full_ready", in_ready, 0);
    step(1, 32'hA005_B005, 5, 0);
    chk("full_hold", in_ready, 0);
    chk("full_head", out_data, 16'hA001);
    beats = 0; took = 0;
    for (int k = 0; k < 20 && !took; k++) begin
      step(1, 32'hA005_B005, 5, 1);
      if (out_valid) beats++;
      took = in_ready;
    end
    chk("fifth_taken", took, 1);
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 0, 1);
      if (out_valid) beats++;
    end
    chk("fill_beats", beats, 10);

    // drop
    step(1, 32'h1234_5678, 7, 1);
    step(1, 32'h0001_0002, 3, 1);
    chk("drop_one", drop_cnt, 1);
    chk("drop_no_out", out_valid, 0);
    step(0, 0, 0, 1);
    chk("drop_hi", out_data, 16'h0001);
    chk("drop_hi_sel", out_sel, 3);
    step(0, 0, 0, 1);
    chk("drop_lo", out_data, 16'h0002);
    chk("drop_lo_last", out_last, 1);
    step(0, 0, 0, 1);
    chk("drop_idle", out_valid, 0);
    for (int k = 0; k < 256; k++) step(1, $urandom, 7, 1);
    step(0, 0, 0, 1);
    chk("drop_sat", drop_cnt, 255);
    chk("drop_sat_idle", out_valid, 0);

    // stall mid-word
    step(1, 32'h1234_5678, 2, 0);
    step(0, 0, 0, 1);
    chk("st_hi", out_data, 16'h1234);
    step(0, 0, 0, 0);
    chk("st_lo0", {out_sel, out_last, out_data}, {3'd2, 1'b1, 16'h5678});
    step(0, 0, 0, 0);
    chk("st_lo1", {out_sel, out_last, out_data}, {3'd2, 1'b1, 16'h5678});
    step(0, 0, 0, 1);
    chk("st_lo2", {out_sel, out_last, out_data}, {3'd2, 1'b1, 16'h5678});
    step(0, 0, 0, 1);
    chk("st_done", out_valid, 0);

    // concurrent push/pop at occupancy 3, across pointer wrap
    for (int k = 0; k < 3; k++) step(1, 32'hC000_0000 + k, 1, 0);
    for (int i = 0; i < 24; i++) begin
      step(i % 2, 32'hD000_0000 + i, 4, 1);
      chk("cc_ready", in_ready, 1);
      chk("cc_last", out_last, i % 2);
    end
    for (int k = 0; k < 10; k++) step(0, 0, 0, 1);
    chk("cc_drained", out_valid, 0);

    // reset mid-word
    step(1, 32'hCAFE_F00D, 1, 1);
    step(0, 0, 0, 1);
    chk("rm_hi", out_data, 16'hCAFE);
    @(posedge clk); #3 rst_n = 0;
    #1;
    chk("rm_valid", out_valid, 0);
    chk("rm_ready", in_ready, 1);
    chk("rm_data", out_data, 0);
    chk("rm_last", out_last, 0);
    chk("rm_sel", out_sel, 0);
    chk("rm_drop", drop_cnt, 0);
    @(posedge clk); #1 rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 1);
      chk("rm_no_lo", out_valid, 0);
    end

    // random traffic
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 1), $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
    for (int k = 0; k < 12; k++) step(0, 0, 0, 1);
    chk("rnd_drained", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
